// File: rtl/adc_sar_sequencer.sv
// SAR ADC conversion sequencer.
// Runs a sample phase followed by a W-bit successive-approximation search.
// The trial code is decoded into row/column/binary switch enables for a
// split capacitor-matrix DAC; those enables depend only on the trial code.
module adc_sar_sequencer #(
    parameter int ROW_BITS      = 4,
    parameter int COL_BITS      = 5,
    parameter int BIN_BITS      = 3,
    parameter int SAMPLE_CYCLES = 2,
    localparam int W    = ROW_BITS + COL_BITS + BIN_BITS,
    localparam int NROW = 1 << ROW_BITS,
    localparam int NCOL = 1 << COL_BITS
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic                comp_in,
    output logic                busy_out,
    output logic                sample_out,
    output logic                valid_out,
    output logic [W-1:0]        result_out,
    output logic [NROW-1:0]     row_n_out,
    output logic [NROW-1:0]     rowon_n_out,
    output logic [NCOL-1:0]     col_n_out,
    output logic [BIN_BITS-1:0] bincap_n_out
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  code_q, code_d;
    logic [W-1:0]  result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] idx_m1;
    logic [7:0]    cnt_q, cnt_d;

    logic [ROW_BITS-1:0] row_sel;
    logic [COL_BITS-1:0] col_sel;

    assign idx_m1 = idx_q - 1'b1;

    // State, trial code, bit index, sample counter and result registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            code_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: sampling countdown and one bit trial per CONVERT cycle
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        result_d = result_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = SAMPLE;
                    code_d  = '0;
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                if (cnt_q == 8'(SAMPLE_CYCLES - 1)) begin
                    state_d = CONVERT;
                    code_d  = {1'b1, {(W-1){1'b0}}};
                    idx_d   = IW'(W - 1);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CONVERT: begin
                // Comparator high means the DAC overshoots: drop the trial bit
                if (comp_in) begin
                    code_d[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    code_d[idx_m1] = 1'b1;
                    idx_d          = idx_m1;
                end else begin
                    state_d  = DONE;
                    result_d = code_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_out   = (state_q != IDLE);
    assign sample_out = (state_q == SAMPLE);
    assign valid_out  = (state_q == DONE);
    assign result_out = result_q;

    assign row_sel = code_q[W-1 -: ROW_BITS];
    assign col_sel = code_q[BIN_BITS +: COL_BITS];

    // Capacitor-matrix decoder: full rows below r, partial row r, column thermometer
    always_comb begin
        rowon_n_out  = '1;
        row_n_out    = '1;
        col_n_out    = '1;
        bincap_n_out = ~code_q[BIN_BITS-1:0];
        for (int k = 0; k < NROW; k++) begin
            rowon_n_out[k] = !(k < int'(row_sel));
            row_n_out[k]   = (k != int'(row_sel));
        end
        for (int j = 0; j < NCOL; j++) begin
            col_n_out[j] = !(j < int'(col_sel));
        end
    end

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Bench for adc_sar_sequencer: default 12-bit instance and an 8-bit instance.
// The comparator is modelled from the DAC switch outputs, as the analog
// front end would see them: comp = (DAC code > vin).
module tb_adc_sar_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, comp_a, start_b, comp_b;

    logic        busy_a, sample_a, valid_a;
    logic [11:0] result_a;
    logic [15:0] row_n_a, rowon_n_a;
    logic [31:0] col_n_a;
    logic [2:0]  bincap_n_a;

    logic        busy_b, sample_b, valid_b;
    logic [7:0]  result_b;
    logic [7:0]  row_n_b, rowon_n_b;
    logic [7:0]  col_n_b;
    logic [1:0]  bincap_n_b;

    int vin_a = 0;
    int vin_b = 0;
    int ra, ca, rb, cb;
    logic [2:0] ba;
    logic [1:0] bb;

    int n_chk  = 0;
    int n_fail = 0;
    int sb[$];

    adc_sar_sequencer dut_a (
        .clk_in(clk), .rst_in(rst), .start_in(start_a), .comp_in(comp_a),
        .busy_out(busy_a), .sample_out(sample_a), .valid_out(valid_a),
        .result_out(result_a), .row_n_out(row_n_a), .rowon_n_out(rowon_n_a),
        .col_n_out(col_n_a), .bincap_n_out(bincap_n_a)
    );

    adc_sar_sequencer #(
        .ROW_BITS(3), .COL_BITS(3), .BIN_BITS(2), .SAMPLE_CYCLES(1)
    ) dut_b (
        .clk_in(clk), .rst_in(rst), .start_in(start_b), .comp_in(comp_b),
        .busy_out(busy_b), .sample_out(sample_b), .valid_out(valid_b),
        .result_out(result_b), .row_n_out(row_n_b), .rowon_n_out(rowon_n_b),
        .col_n_out(col_n_b), .bincap_n_out(bincap_n_b)
    );

    // Comparator models: reconstruct DAC code from the switch pattern
    always_comb begin
        ra = 0; ca = 0; ba = ~bincap_n_a;
        for (int k = 0; k < 16; k++) if (!row_n_a[k]) ra = k;
        for (int j = 0; j < 32; j++) if (!col_n_a[j]) ca++;
        comp_a = ((ra << 8) | (ca << 3) | int'(ba)) > vin_a;
    end

    always_comb begin
        rb = 0; cb = 0; bb = ~bincap_n_b;
        for (int k = 0; k < 8; k++) if (!row_n_b[k]) rb = k;
        for (int j = 0; j < 8; j++) if (!col_n_b[j]) cb++;
        comp_b = ((rb << 5) | (cb << 2) | int'(bb)) > vin_b;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    // One conversion: push expected code, pulse start, wait for valid, compare
    task automatic conv(input bit sel, input int vin, input bit glitch);
        int lat, nbusy, nsamp, exp_lat, exp;
        exp_lat = sel ? 9 : 14;
        if (sel) vin_b = vin; else vin_a = vin;
        sb.push_back(vin);
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
        lat = 0; nbusy = 0; nsamp = 0;
        while (!(sel ? valid_b : valid_a) && lat < 60) begin
            if (sel ? busy_b : busy_a) nbusy++;
            if (sel ? sample_b : sample_a) nsamp++;
            set_start(sel, glitch && (lat == 0 || lat == 6));
            @(negedge clk); lat++;
        end
        if (sel ? busy_b : busy_a) nbusy++;
        check(sel ? "lat_b" : "lat_a", 64'(lat), 64'(exp_lat));
        exp = sb.pop_front();
        check(sel ? "result_b" : "result_a", sel ? 64'(result_b) : 64'(result_a), 64'(exp));
        check(sel ? "busy_cycles_b" : "busy_cycles_a", 64'(nbusy), 64'(exp_lat + 1));
        check(sel ? "sample_cycles_b" : "sample_cycles_a", 64'(nsamp), sel ? 64'd1 : 64'd2);
        @(negedge clk);
        check(sel ? "idle_after_b" : "idle_after_a", sel ? 64'(busy_b) : 64'(busy_a), 64'd0);
    endtask

    task automatic check_reset_outputs_a(input string tag);
        check({tag, "_busy"},   64'(busy_a),     64'd0);
        check({tag, "_sample"}, 64'(sample_a),   64'd0);
        check({tag, "_valid"},  64'(valid_a),    64'd0);
        check({tag, "_result"}, 64'(result_a),   64'd0);
        check({tag, "_row"},    64'(row_n_a),    64'hFFFE);
        check({tag, "_rowon"},  64'(rowon_n_a),  64'hFFFF);
        check({tag, "_col"},    64'(col_n_a),    64'hFFFF_FFFF);
        check({tag, "_bincap"}, 64'(bincap_n_a), 64'h7);
    endtask

    initial begin
        int gap;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs_a("rst_a");
        check("rst_b_row", 64'(row_n_b), 64'hFE);
        check("rst_b_busy", 64'(busy_b), 64'd0);
        rst = 1'b0;

        // Mid-scale conversion with timing, then decoder pattern for 2048
        conv(0, 2048, 0);
        check("dec2048_row",   64'(row_n_a),    64'hFEFF);
        check("dec2048_rowon", 64'(rowon_n_a),  64'hFF00);
        check("dec2048_col",   64'(col_n_a),    64'hFFFF_FFFF);
        check("dec2048_bin",   64'(bincap_n_a), 64'h7);

        // start pulses during SAMPLE and CONVERT are ignored
        conv(0, 2048, 1);

        // End points and full-scale decoder pattern
        conv(0, 0, 0);
        conv(0, 4095, 0);
        check("dec4095_row",   64'(row_n_a),    64'h7FFF);
        check("dec4095_rowon", 64'(rowon_n_a),  64'h8000);
        check("dec4095_col",   64'(col_n_a),    64'h8000_0000);
        check("dec4095_bin",   64'(bincap_n_a), 64'h0);
        repeat (3) @(negedge clk);
        check("hold_result", 64'(result_a), 64'd4095);

        // Asynchronous reset during CONVERT cycle 5
        vin_a = 3000;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs_a("abort");
        repeat (3) begin
            @(negedge clk);
            check("abort_no_valid", 64'(valid_a), 64'd0);
        end
        rst = 1'b0;
        conv(0, 3000, 0);

        // start held high: back-to-back conversions, one IDLE cycle between
        vin_a = 1000;
        sb.push_back(1000); sb.push_back(1000);
        @(negedge clk); start_a = 1'b1;
        gap = 0;
        while (!valid_a && gap < 60) begin @(negedge clk); gap++; end
        check("b2b_result1", 64'(result_a), 64'(sb.pop_front()));
        gap = 0;
        do begin @(negedge clk); gap++; end while (!valid_a && gap < 60);
        check("b2b_gap", 64'(gap), 64'd16);
        check("b2b_result2", 64'(result_a), 64'(sb.pop_front()));
        start_a = 1'b0;
        @(negedge clk);
        check("b2b_idle", 64'(busy_a), 64'd0);

        // 8-bit instance sweep
        for (int v = 0; v < 256; v++) conv(1, v, 0);

        // 12-bit instance sweep
        for (int v = 0; v < 4096; v++) conv(0, v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
